// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: front-end controller for the stack-based ALU.
// Buffers an instruction stream in a small FIFO, checks each instruction
// against a shadow copy of the ALU stack depth, issues legal ones one at
// a time and returns popped values and sticky status flags.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on the registered FIFO
// count, and in_valid/in_opcode/in_data must stay stable until accepted.
module stack_alu_sequencer #(
    parameter int N           = 5,
    parameter int FIFO_DEPTH  = 4,
    parameter int STACK_DEPTH = 8,
    parameter int ALU_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [2:0]                       in_opcode,
    input  logic [N-1:0]                     in_data,
    output logic [2:0]                       alu_opcode,
    output logic [N-1:0]                     alu_input_data,
    input  logic [N-1:0]                     alu_output_data,
    input  logic                             alu_overflow,
    output logic                             result_valid,
    output logic [N-1:0]                     result_data,
    output logic                             ovf_flag,
    output logic                             err_underflow,
    output logic                             err_stack_full,
    input  logic                             clr_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             busy,
    output logic [1:0]                       dbg_state
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(ALU_LATENCY + 1);

    localparam logic [DW-1:0] STACK_MAX = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] TWO       = DW'(2);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WAIT_INIT = WW'(ALU_LATENCY - 1);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // ---------------- FIFO storage and pointers ----------------
    logic [2:0]    fifo_op_q   [FIFO_DEPTH];
    logic [N-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en;
    logic          fifo_rd;

    // ---------------- FSM and datapath registers ----------------
    state_t        state_q, state_d;
    logic [2:0]    issue_op_q, issue_op_d;
    logic [N-1:0]  issue_data_q, issue_data_d;
    logic [N-1:0]  last_data_q, last_data_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          res_valid_q, res_valid_d;
    logic [N-1:0]  res_data_q, res_data_d;
    logic          ovf_q, ovf_d;
    logic          uf_q, uf_d;
    logic          full_q, full_d;
    logic          issue_ok;
    logic          set_ovf, set_uf, set_full;

    assign in_ready       = (count_q < FIFO_FULL);
    assign wr_en          = in_valid && in_ready;
    assign busy           = (state_q != S_IDLE) || (count_q != '0);
    assign depth          = depth_q;
    assign result_valid   = res_valid_q;
    assign result_data    = res_data_q;
    assign ovf_flag       = ovf_q;
    assign err_underflow  = uf_q;
    assign err_stack_full = full_q;
    assign dbg_state      = state_q;

    // FIFO entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_op_q[wr_ptr_q]   <= in_opcode;
            fifo_data_q[wr_ptr_q] <= in_data;
        end
    end

    // FIFO occupancy: a simultaneous write and read leaves the count alone.
    always_comb begin
        count_d = count_q;
        case ({wr_en, fifo_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and count; pointers wrap because FIFO_DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Next-state, legality check, ALU drive and status updates.
    always_comb begin
        state_d        = state_q;
        issue_op_d     = issue_op_q;
        issue_data_d   = issue_data_q;
        last_data_d    = last_data_q;
        wait_cnt_d     = wait_cnt_q;
        depth_d        = depth_q;
        res_valid_d    = 1'b0;
        res_data_d     = res_data_q;
        fifo_rd        = 1'b0;
        issue_ok       = 1'b0;
        set_ovf        = 1'b0;
        set_uf         = 1'b0;
        set_full       = 1'b0;
        alu_opcode     = OP_NOP;
        alu_input_data = last_data_q;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    fifo_rd      = 1'b1;
                    issue_op_d   = fifo_op_q[rd_ptr_q];
                    issue_data_d = fifo_data_q[rd_ptr_q];
                    state_d      = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Illegal instructions and NOPs fall back to IDLE and are dropped.
                state_d = S_IDLE;
                case (issue_op_q)
                    OP_PUSH: begin
                        if (depth_q < STACK_MAX) begin
                            issue_ok = 1'b1;
                            depth_d  = depth_q + DW'(1);
                        end else begin
                            set_full = 1'b1;
                        end
                    end
                    OP_ADD, OP_MUL: begin
                        if (depth_q >= TWO) begin
                            issue_ok = 1'b1;
                            depth_d  = depth_q - DW'(1);
                        end else begin
                            set_uf = 1'b1;
                        end
                    end
                    OP_POP: begin
                        if (depth_q != '0) begin
                            issue_ok = 1'b1;
                            depth_d  = depth_q - DW'(1);
                        end else begin
                            set_uf = 1'b1;
                        end
                    end
                    default: begin
                        issue_ok = 1'b0;
                    end
                endcase
                if (issue_ok) begin
                    alu_opcode     = issue_op_q;
                    alu_input_data = issue_data_q;
                    last_data_d    = issue_data_q;
                    wait_cnt_d     = WAIT_INIT;
                    state_d        = S_WAIT;
                end
            end

            S_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (issue_op_q == OP_POP) begin
                        res_valid_d = 1'b1;
                        res_data_d  = alu_output_data;
                    end
                    if ((issue_op_q == OP_ADD) || (issue_op_q == OP_MUL)) begin
                        set_ovf = alu_overflow;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - WW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Sticky flags: clear first, so a same-edge set event wins.
        ovf_d  = (clr_err ? 1'b0 : ovf_q)  | set_ovf;
        uf_d   = (clr_err ? 1'b0 : uf_q)   | set_uf;
        full_d = (clr_err ? 1'b0 : full_q) | set_full;
    end

    // FSM state, issue register, depth tracker, result and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            issue_op_q   <= OP_NOP;
            issue_data_q <= '0;
            last_data_q  <= '0;
            wait_cnt_q   <= '0;
            depth_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            ovf_q        <= 1'b0;
            uf_q         <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_op_q   <= issue_op_d;
            issue_data_q <= issue_data_d;
            last_data_q  <= last_data_d;
            wait_cnt_q   <= wait_cnt_d;
            depth_q      <= depth_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            ovf_q        <= ovf_d;
            uf_q         <= uf_d;
            full_q       <= full_d;
        end
    end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer with a behavioural stack ALU
// (one-cycle latency) attached to the ALU-side ports.
module tb_stack_alu_sequencer;

    localparam int N   = 5;
    localparam int FD  = 4;
    localparam int SD  = 8;
    localparam int LAT = 1;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] MUL  = 3'b101;
    localparam logic [2:0] PUSH = 3'b110;
    localparam logic [2:0] POP  = 3'b111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic         in_valid, in_ready, clr_err;
    logic [2:0]   in_opcode, alu_opcode;
    logic [N-1:0] in_data, alu_input_data, alu_output_data, result_data;
    logic         alu_overflow, result_valid, ovf_flag, err_underflow, err_stack_full, busy;
    logic [3:0]   depth;
    logic [1:0]   dbg_state;

    stack_alu_sequencer #(.N(N), .FIFO_DEPTH(FD), .STACK_DEPTH(SD), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_data(in_data), .alu_opcode(alu_opcode),
        .alu_input_data(alu_input_data), .alu_output_data(alu_output_data),
        .alu_overflow(alu_overflow), .result_valid(result_valid),
        .result_data(result_data), .ovf_flag(ovf_flag),
        .err_underflow(err_underflow), .err_stack_full(err_stack_full),
        .clr_err(clr_err), .depth(depth), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- behavioural stack ALU ----------------
    logic [N-1:0] alu_stk [0:15];
    int           sp;
    logic [5:0]   sum;
    logic [9:0]   prod;

    always @(posedge clk) begin
        if (rst) begin
            sp = 0;
            alu_output_data <= '0;
            alu_overflow    <= 1'b0;
        end else begin
            case (alu_opcode)
                PUSH: if (sp < 16) begin alu_stk[sp] = alu_input_data; sp++; end
                ADD: if (sp >= 2) begin
                    sum = {1'b0, alu_stk[sp-1]} + {1'b0, alu_stk[sp-2]};
                    alu_stk[sp-2] = sum[4:0]; sp--;
                    alu_output_data <= sum[4:0]; alu_overflow <= sum[5];
                end
                MUL: if (sp >= 2) begin
                    prod = alu_stk[sp-1] * alu_stk[sp-2];
                    alu_stk[sp-2] = prod[4:0]; sp--;
                    alu_output_data <= prod[4:0]; alu_overflow <= |prod[9:5];
                end
                POP: if (sp >= 1) begin alu_output_data <= alu_stk[sp-1]; sp--; end
                default: ;
            endcase
        end
    end

    // ---------------- monitors ----------------
    logic [7:0]   issued_q [$];
    logic [N-1:0] res_q [$];
    int           res_cyc_q [$];

    always @(negedge clk) begin
        if (!rst && alu_opcode != NOP) issued_q.push_back({alu_opcode, alu_input_data});
        if (result_valid) begin
            res_q.push_back(result_data);
            res_cyc_q.push_back(cyc);
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0]   exp_q [$];
    logic [N-1:0] exp_r [$];
    int checks   = 0;
    int failures = 0;
    int last_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_issued(input string tag);
        check({tag, "_issue_count"}, issued_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_issue_word"}, (i < issued_q.size()) ? issued_q[i] : 8'hxx, exp_q[i]);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_res_count"}, res_q.size(), exp_r.size());
        for (int i = 0; i < exp_r.size(); i++) begin
            check({tag, "_res_data"}, (i < res_q.size()) ? res_q[i] : 5'hxx, exp_r[i]);
        end
    endtask

    task automatic clear_logs();
        issued_q.delete(); res_q.delete(); res_cyc_q.delete();
        exp_q.delete(); exp_r.delete();
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [N-1:0] d);
        int n = 0;
        in_valid = 1'b1; in_opcode = op; in_data = d;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("send_ready_timeout", in_ready, 1);
        @(negedge clk);
        last_acc = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] s);
        int n = 0;
        while (dbg_state != s && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check("state_timeout", dbg_state, s);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        in_valid = 1'b0; in_opcode = NOP; in_data = '0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_depth", depth, 0);
        check("rst_alu_opcode", alu_opcode, NOP);
        check("rst_alu_input", alu_input_data, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_data", result_data, 0);
        check("rst_flags", {ovf_flag, err_underflow, err_stack_full}, 0);
        check("rst_busy", busy, 0);

        // 22 + 18 = 40 -> 8 with overflow, back-to-back
        clear_logs();
        send(PUSH, 5'b10110); send(PUSH, 5'b10010); send(ADD, 0); send(POP, 0);
        in_valid = 1'b0;
        wait_idle();
        exp_q = '{{PUSH, 5'b10110}, {PUSH, 5'b10010}, {ADD, 5'd0}, {POP, 5'd0}};
        exp_r = '{5'b01000};
        check_issued("add");
        check_results("add");
        check("add_ovf", ovf_flag, 1);
        check("add_depth", depth, 0);
        check("add_no_err", {err_underflow, err_stack_full}, 0);

        // clr_err drops ovf; 8 * 10 = 80 -> 16 with overflow; isolated pop timing
        pulse_clr();
        check("clr_ovf", ovf_flag, 0);
        clear_logs();
        send(PUSH, 5'b01000); send(PUSH, 5'b01010); send(MUL, 0);
        in_valid = 1'b0;
        wait_idle();
        check("mul_depth", depth, 1);
        check("mul_ovf", ovf_flag, 1);
        send(POP, 0);
        in_valid = 1'b0;
        wait_idle();
        exp_r = '{5'b10000};
        check_results("mul");
        check("pop_latency", (res_cyc_q.size() > 0) ? res_cyc_q[0] : -1, last_acc + 2 + LAT);
        check("pop_pulse_low", result_valid, 0);
        pulse_clr();
        check("mul_clr_ovf", ovf_flag, 0);

        // Underflow: pop on empty, add with depth 1
        clear_logs();
        send(POP, 0);
        in_valid = 1'b0;
        wait_idle();
        check("uf_pop_flag", err_underflow, 1);
        check("uf_pop_depth", depth, 0);
        check("uf_pop_no_issue", issued_q.size(), 0);
        pulse_clr();
        check("uf_clr", err_underflow, 0);
        send(PUSH, 5'd3); send(ADD, 0);
        in_valid = 1'b0;
        wait_idle();
        check("uf_add_flag", err_underflow, 1);
        check("uf_add_depth", depth, 1);
        send(POP, 0);
        in_valid = 1'b0;
        wait_idle();
        exp_q = '{{PUSH, 5'd3}, {POP, 5'd0}};
        exp_r = '{5'd3};
        check_issued("uf");
        check_results("uf");
        pulse_clr();

        // Stack full: 9 pushes, then set-vs-clear at the same edge
        clear_logs();
        for (int i = 1; i <= SD + 1; i++) send(PUSH, 5'(i));
        in_valid = 1'b0;
        wait_idle();
        for (int i = 1; i <= SD; i++) exp_q.push_back({PUSH, 5'(i)});
        check_issued("full");
        check("full_flag", err_stack_full, 1);
        check("full_depth", depth, SD);
        check("full_no_uf", err_underflow, 0);
        clr_err = 1'b1;
        send(PUSH, 5'd10);
        in_valid = 1'b0;
        check("full_cleared", err_stack_full, 0);
        wait_state(2'd1);
        @(negedge clk);
        clr_err = 1'b0;
        check("full_set_wins", err_stack_full, 1);
        @(negedge clk);
        check("full_sticky", err_stack_full, 1);
        check("full_depth_hold", depth, SD);
        wait_idle();
        for (int i = 0; i < SD; i++) send(POP, 0);
        in_valid = 1'b0;
        wait_idle();
        for (int i = SD; i >= 1; i--) exp_r.push_back(5'(i));
        check_results("drain");
        check("drain_depth", depth, 0);
        pulse_clr();

        // Backpressure: 6 instructions held back-to-back
        clear_logs();
        for (int i = 0; i < 6; i++) send(PUSH, 5'(11 + i));
        in_valid = 1'b0;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_busy", busy, 1);
        wait_idle();
        for (int i = 0; i < 6; i++) exp_q.push_back({PUSH, 5'(11 + i)});
        check_issued("bp");
        check("bp_depth", depth, 6);
        for (int i = 0; i < 6; i++) send(POP, 0);
        in_valid = 1'b0;
        wait_idle();
        for (int i = 5; i >= 0; i--) exp_r.push_back(5'(11 + i));
        check_results("bp");

        // Reset during WAIT of a pop, with another instruction queued
        clear_logs();
        send(PUSH, 5'd7);
        in_valid = 1'b0;
        wait_idle();
        send(POP, 0); send(PUSH, 5'd9);
        in_valid = 1'b0;
        wait_state(2'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_result_valid", result_valid, 0);
        check("mid_rst_depth", depth, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_state", dbg_state, 0);
        repeat (5) @(negedge clk);
        exp_q = '{{PUSH, 5'd7}, {POP, 5'd0}};
        check_issued("mid_rst");
        check("mid_rst_no_result", res_q.size(), 0);

        // NOP-class opcodes: no issue, no depth change, no error
        clear_logs();
        send(3'b000, 5'd5); send(3'b011, 5'd7); send(3'b001, 5'd1);
        in_valid = 1'b0;
        wait_idle();
        check("nop_depth", depth, 0);
        check("nop_no_issue", issued_q.size(), 0);
        check("nop_flags", {ovf_flag, err_underflow, err_stack_full}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
